// File: rtl/mem_arbiter.sv
// Two-port block-transaction arbiter: I-cache and D-cache share one registered
// memory port, one whole read-allocate or write-back at a time.
module mem_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        state_dbg
);

  // Handshake: a port holds read/write with stable address/data until its
  // one-cycle ready pulse; memory sees the same contract on mem_* / mem_ready.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state;
  logic       last_grant_d;
  logic       i_req;
  logic       d_req;
  logic       pick_i;
  logic       pick_d;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // On a tie, round-robin favours the port not served last; mode 1 favours D.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (i_req && d_req) begin
      if (PRIO_MODE == 0) begin
        pick_i = last_grant_d;
        pick_d = !last_grant_d;
      end else begin
        pick_d = 1'b1;
      end
    end else begin
      pick_i = i_req;
      pick_d = d_req;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write dominates when a port raises both strobes.
          if (pick_i) begin
            state     <= GNT_I;
            mem_write <= i_write;
            mem_read  <= i_read & ~i_write;
            mem_addr  <= i_addr;
            mem_wdata <= i_wdata;
          end else if (pick_d) begin
            state     <= GNT_D;
            mem_write <= d_write;
            mem_read  <= d_read & ~d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            last_grant_d <= (state == GNT_D);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_ready   = (state == GNT_I) && mem_ready;
  assign d_ready   = (state == GNT_D) && mem_ready;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: two cache drivers, a memory responder,
// a transaction-level reference model and a negedge monitor/scoreboard.
module tb_mem_arbiter;

  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int NTX = 40;
  localparam int EW  = 2 + AW + DW;

  logic          clk = 1'b0;
  logic          proc_reset_n = 1'b0;
  logic          i_read = 1'b0, i_write = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic [1:0]    state_dbg;

  // Second instance with D priority, driven by a short directed sequence.
  logic          p_i_read = 1'b0, p_d_read = 1'b0;
  logic [AW-1:0] p_i_addr = '0, p_d_addr = '0;
  logic [DW-1:0] p_i_rdata, p_d_rdata;
  logic          p_i_ready, p_d_ready;
  logic          p_mem_read, p_mem_write;
  logic [AW-1:0] p_mem_addr;
  logic [DW-1:0] p_mem_wdata;
  logic [DW-1:0] p_mem_rdata = '0;
  logic          p_mem_ready = 1'b0;
  logic [1:0]    p_state_dbg;
  logic          zero1 = 1'b0;
  logic [DW-1:0] zero_d = '0;

  int tests = 0;
  int fails = 0;
  bit mem_en = 1'b0;

  // Reference model: whole-transaction view of the shared bus.
  bit          model_busy = 1'b0;
  bit          model_owner_d = 1'b0;
  bit          model_last_d = 1'b1;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur = '0;
  bit          prev_strobe = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .state_dbg(state_dbg)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(p_i_read), .i_write(zero1), .i_addr(p_i_addr), .i_wdata(zero_d),
    .i_rdata(p_i_rdata), .i_ready(p_i_ready),
    .d_read(p_d_read), .d_write(zero1), .d_addr(p_d_addr), .d_wdata(zero_d),
    .d_rdata(p_d_rdata), .d_ready(p_d_ready),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
    .state_dbg(p_state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit is_d, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (is_d) begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = w;
    end else begin
      i_read = rd; i_write = wr; i_addr = a; i_wdata = w;
    end
  endtask

  task automatic drop_req(input bit is_d);
    if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
    else begin i_read = 1'b0; i_write = 1'b0; end
  endtask

  // Model: an idle bus picks a winner from the requests present, a busy bus
  // finishes on mem_ready, and at least one idle cycle separates grants.
  always @(posedge clk or negedge proc_reset_n) begin : model
    bit ir, dr, win_d, wr;
    if (!proc_reset_n) begin
      model_busy   <= 1'b0;
      model_last_d <= 1'b1;
      exp_q.delete();
    end else if (!model_busy) begin
      ir = i_read | i_write;
      dr = d_read | d_write;
      if (ir || dr) begin
        win_d = ir ? (dr && !model_last_d) : 1'b1;
        wr    = win_d ? d_write : i_write;
        exp_q.push_back(win_d ? {wr, 1'b1, d_addr, d_wdata} : {wr, 1'b0, i_addr, i_wdata});
        model_owner_d <= win_d;
        model_busy    <= 1'b1;
      end
    end else if (mem_ready) begin
      model_busy   <= 1'b0;
      model_last_d <= model_owner_d;
    end
  end

  // Monitor: pops an expected grant on each rising memory strobe and checks
  // ready routing and bus stability every cycle.
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    logic strobe;
    if (!proc_reset_n) begin
      prev_strobe <= 1'b0;
    end else begin
      strobe = mem_read | mem_write;
      chk("strobe_vs_model", strobe, model_busy);
      if (strobe && !prev_strobe) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          e = exp_q.pop_front();
          cur <= e;
          chk("grant_mem_write", mem_write, e[EW-1]);
          chk("grant_mem_read", mem_read, !e[EW-1]);
          chk("grant_mem_addr", mem_addr, e[AW+DW-1:DW]);
          chk("grant_mem_wdata", mem_wdata, e[DW-1:0]);
        end
      end else if (strobe) begin
        chk("hold_mem_write", mem_write, cur[EW-1]);
        chk("hold_mem_addr", mem_addr, cur[AW+DW-1:DW]);
        chk("hold_mem_wdata", mem_wdata, cur[DW-1:0]);
      end
      chk("i_ready", i_ready, model_busy && !model_owner_d && mem_ready);
      chk("d_ready", d_ready, model_busy && model_owner_d && mem_ready);
      if (i_ready) chk("i_rdata", i_rdata, mem_rdata);
      if (d_ready) chk("d_rdata", d_rdata, mem_rdata);
      prev_strobe <= strobe;
    end
  end

  // Memory: random completion latency, plus stray mem_ready pulses when idle.
  initial begin : responder
    int lat;
    lat = 1;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (mem_en && proc_reset_n) begin
        if (mem_read | mem_write) begin
          if (lat == 0) begin
            mem_ready = 1'b1;
            mem_rdata = rand_data();
            lat = $urandom_range(0, 3);
          end else begin
            lat--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_ready = 1'b1;
          mem_rdata = rand_data();
        end
      end
    end
  end

  task automatic run_port(input bit is_d);
    logic rd, wr;
    bit got;
    int n, gap, op;
    for (int t = 0; t < NTX; t++) begin
      gap = (t == 0) ? 0 : $urandom_range(0, 2);
      if (gap > 0) begin
        drop_req(is_d);
        repeat (gap) begin @(posedge clk); #1; end
      end
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      set_req(is_d, rd, wr, AW'($urandom), rand_data());
      got = 1'b0;
      n = 0;
      while (!got && n < 400) begin
        @(negedge clk);
        n++;
        if (is_d ? d_ready : i_ready) got = 1'b1;
        else if (model_busy && (model_owner_d == is_d)) begin
          // Granted: scribble on inputs or withdraw; the bus must not notice.
          if ($urandom_range(0, 3) == 0) set_req(is_d, rd, wr, AW'($urandom), rand_data());
          else if ($urandom_range(0, 5) == 0) drop_req(is_d);
        end
      end
      chk(is_d ? "d_ready_timeout" : "i_ready_timeout", got, 1);
      @(posedge clk);
      #1;
    end
    set_req(is_d, 0, 0, '0, '0);
  endtask

  task automatic wait_strobe(input string name, input bit prio);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(prio ? p_mem_read : mem_read) && n < 10);
    chk(name, prio ? p_mem_read : mem_read, 1);
  endtask

  initial begin : main
    logic [DW-1:0] w;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_state", state_dbg, 0);
    @(posedge clk);
    #1;
    proc_reset_n = 1'b1;

    // D priority: D wins every round while both ports hold their requests.
    p_i_read = 1'b1; p_i_addr = 28'h0000111;
    p_d_read = 1'b1; p_d_addr = 28'h0000222;
    for (int k = 0; k < 4; k++) begin
      wait_strobe("prio_strobe", 1'b1);
      chk("prio_grant_addr", p_mem_addr, 28'h0000222);
      @(posedge clk);
      #1;
      p_mem_ready = 1'b1;
      p_mem_rdata = rand_data();
      @(negedge clk);
      chk("prio_d_ready", p_d_ready, 1);
      chk("prio_i_ready", p_i_ready, 0);
      chk("prio_d_rdata", p_d_rdata, p_mem_rdata);
      @(posedge clk);
      #1;
      p_mem_ready = 1'b0;
      @(negedge clk);
      chk("prio_idle_gap", p_mem_read, 0);
    end
    p_i_read = 1'b0;
    p_d_read = 1'b0;

    // Randomised contention on the round-robin instance.
    @(posedge clk);
    #1;
    mem_en = 1'b1;
    fork
      run_port(1'b0);
      run_port(1'b1);
    join
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of a D transaction, then a tie must go to I.
    mem_en = 1'b0;
    set_req(1, 1, 0, 28'h0ABCDEF, rand_data());
    wait_strobe("rst_test_strobe", 1'b0);
    chk("rst_test_grant_d", mem_addr, 28'h0ABCDEF);
    #2;
    proc_reset_n = 1'b0;
    #1;
    chk("async_rst_mem_read", mem_read, 0);
    chk("async_rst_mem_write", mem_write, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_mem_wdata", mem_wdata, 0);
    chk("async_rst_state", state_dbg, 0);
    drop_req(1);
    @(posedge clk);
    #1;
    proc_reset_n = 1'b1;
    w = rand_data();
    set_req(0, 1, 0, 28'h0000123, w);
    set_req(1, 1, 0, 28'h0000456, rand_data());
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_tie_read", mem_read, 1);
    chk("post_rst_tie_addr", mem_addr, 28'h0000123);
    mem_en = 1'b1;
    @(posedge clk);
    #1;
    drop_req(0);
    drop_req(1);
    repeat (20) @(posedge clk);
    chk("drain_exp_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
